// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// serial_adder : digit-serial WIDTH-bit adder, DIGIT bits per clock, LSB first
// Revision     : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int STEPS   = WIDTH / DIGIT;
    localparam int c_CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(STEPS - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_adder: WIDTH must be at least 2");
    end
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("serial_adder: DIGIT must divide WIDTH exactly");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic               w_accept;
    logic               w_last;
    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_b_dig;
    logic [DIGIT:0]     w_slice;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == c_LAST);
    assign w_a_dig  = r_a[DIGIT-1:0];
    assign w_b_dig  = r_b[DIGIT-1:0];
    assign w_slice  = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Constant-index digit write keeps the select widths exact.
    always_comb begin
        w_sum_nxt = r_sum;
        for (int i = 0; i < STEPS; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
                w_sum_nxt[i*DIGIT +: DIGIT] = w_slice[DIGIT-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_slice[DIGIT];
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            if (w_last) begin
                // The last digit carries the operand MSBs and the sum MSB.
                r_cnt  <= '0;
                r_cout <= w_slice[DIGIT];
                r_ovf  <= (w_a_dig[DIGIT-1] == w_b_dig[DIGIT-1]) &&
                          (w_slice[DIGIT-1] != w_a_dig[DIGIT-1]);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// tb_serial_adder : scoreboard bench for three serial_adder configurations
// Revision        : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic        st0 = 0, ci0 = 0, co0, ov0, bz0, dn0;
    logic [7:0]  a0 = 0, b0 = 0, s0;
    logic        st1 = 0, ci1 = 0, co1, ov1, bz1, dn1;
    logic [15:0] a1 = 0, b1 = 0, s1;
    logic        st2 = 0, ci2 = 0, co2, ov2, bz2, dn2;
    logic [7:0]  a2 = 0, b2 = 0, s2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .cin(ci0),
        .sum(s0), .cout(co0), .ovf(ov0), .busy(bz0), .done(dn0));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(ci1),
        .sum(s1), .cout(co1), .ovf(ov1), .busy(bz1), .done(dn1));
    serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .cin(ci2),
        .sum(s2), .cout(co2), .ovf(ov2), .busy(bz2), .done(dn2));

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic ci, int acc);
        logic [16:0] full;
        exp_t        e;
        full   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        e.sum  = 16'(full & ((17'd1 << w) - 17'd1));
        e.cout = full[w];
        e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        e.acc  = acc;
        return e;
    endfunction

    // Scoreboards: each done pops one expected result; latency = accept edge to done-cycle edge.
    always @(negedge clk) begin
        if (dn0) begin
            if (q0.size() == 0) check("w8d1 unexpected done", 32'(dn0), 32'd0);
            else begin
                e0 = q0.pop_front();
                check("w8d1 sum", 32'(s0), 32'(e0.sum));
                check("w8d1 cout", 32'(co0), 32'(e0.cout));
                check("w8d1 ovf", 32'(ov0), 32'(e0.ovf));
                check("w8d1 latency", 32'(cyc + 1 - e0.acc), 32'd9);
            end
        end
        if (dn1) begin
            if (q1.size() == 0) check("w16d4 unexpected done", 32'(dn1), 32'd0);
            else begin
                e1 = q1.pop_front();
                check("w16d4 sum", 32'(s1), 32'(e1.sum));
                check("w16d4 cout", 32'(co1), 32'(e1.cout));
                check("w16d4 ovf", 32'(ov1), 32'(e1.ovf));
                check("w16d4 latency", 32'(cyc + 1 - e1.acc), 32'd5);
            end
        end
        if (dn2) begin
            if (q2.size() == 0) check("w8d8 unexpected done", 32'(dn2), 32'd0);
            else begin
                e2 = q2.pop_front();
                check("w8d8 sum", 32'(s2), 32'(e2.sum));
                check("w8d8 cout", 32'(co2), 32'(e2.cout));
                check("w8d8 ovf", 32'(ov2), 32'(e2.ovf));
                check("w8d8 latency", 32'(cyc + 1 - e2.acc), 32'd2);
            end
        end
    end

    task automatic op0(logic [7:0] a, logic [7:0] b, logic ci,
                       logic [7:0] xs, logic xc, logic xo);
        @(negedge clk);
        a0 = a; b0 = b; ci0 = ci; st0 = 1'b1;
        q0.push_back(model(8, a, b, ci, cyc + 1));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            st0 = 1'b0;
            check("w8d1 busy in run", 32'(bz0), 32'd1);
            check("w8d1 done in run", 32'(dn0), 32'd0);
        end
        @(negedge clk);
        check("w8d1 done pulse", 32'(dn0), 32'd1);
        check("w8d1 busy at done", 32'(bz0), 32'd0);
        check("w8d1 directed sum", 32'(s0), 32'(xs));
        check("w8d1 directed cout", 32'(co0), 32'(xc));
        check("w8d1 directed ovf", 32'(ov0), 32'(xo));
        @(negedge clk);
        check("w8d1 done one cycle", 32'(dn0), 32'd0);
        check("w8d1 sum held", 32'(s0), 32'(xs));
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle sum0", 32'(s0), 32'd0);
            check("idle cout0", 32'(co0), 32'd0);
            check("idle ovf0", 32'(ov0), 32'd0);
            check("idle busy0", 32'(bz0), 32'd0);
            check("idle done0", 32'(dn0), 32'd0);
            check("idle sum1", 32'(s1), 32'd0);
            check("idle busy1", 32'(bz1), 32'd0);
            check("idle sum2", 32'(s2), 32'd0);
            check("idle busy2", 32'(bz2), 32'd0);
        end

        // Directed adds
        op0(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
        op0(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op0(8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1);
        op0(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Back-to-back with start held and operands changing every cycle
        for (int j = 0; j < 27; j++) begin
            @(negedge clk);
            st0 = 1'b1;
            a0  = 8'($urandom);
            b0  = 8'($urandom);
            ci0 = 1'($urandom);
            if ((j % 9) == 0) q0.push_back(model(8, a0, b0, ci0, cyc + 1));
        end
        @(negedge clk);
        st0 = 1'b0;
        @(negedge clk);
        check("w8d1 idle after b2b", 32'(bz0 | dn0), 32'd0);

        // Reset during RUN cycle 4: the operation must vanish
        @(negedge clk);
        a0 = 8'hAA; b0 = 8'h55; ci0 = 1'b0; st0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            st0 = 1'b0;
            check("w8d1 busy before reset", 32'(bz0), 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset mid sum", 32'(s0), 32'd0);
        check("reset mid cout", 32'(co0), 32'd0);
        check("reset mid ovf", 32'(ov0), 32'd0);
        check("reset mid busy", 32'(bz0), 32'd0);
        check("reset mid done", 32'(dn0), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no done after reset", 32'(dn0), 32'd0);
        end

        // Random sweep WIDTH=16 DIGIT=4, back-to-back every 5 cycles
        for (int j = 0; j < 5000; j++) begin
            @(negedge clk);
            st1 = 1'b1;
            a1  = 16'($urandom);
            b1  = 16'($urandom);
            ci1 = 1'($urandom);
            if ((j % 5) == 0) q1.push_back(model(16, a1, b1, ci1, cyc + 1));
        end
        @(negedge clk);
        st1 = 1'b0;

        // Random sweep WIDTH=8 DIGIT=8, back-to-back every 2 cycles
        for (int j = 0; j < 2000; j++) begin
            @(negedge clk);
            st2 = 1'b1;
            a2  = 8'($urandom);
            b2  = 8'($urandom);
            ci2 = 1'($urandom);
            if ((j % 2) == 0) q2.push_back(model(8, a2, b2, ci2, cyc + 1));
        end
        @(negedge clk);
        st2 = 1'b0;

        for (int i = 0; i < 100 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
        check("w8d1 results outstanding", 32'(q0.size()), 32'd0);
        check("w16d4 results outstanding", 32'(q1.size()), 32'd0);
        check("w8d8 results outstanding", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle, parametrised successor to the team's combinational half/full adders.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first, using one DIGIT-wide adder slice and a registered carry.
- Trades latency for area in arithmetic datapaths.
- Has a start/busy/done handshake plus unsigned carry and signed overflow flags.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
- STEPS (localparam), WIDTH/DIGIT, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- sum  output  WIDTH  result register.
- cout  output  1  unsigned carry-out of the MSB.
- ovf  output  1  two's-complement overflow.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.

Behaviour:
- Reset: synchronous, active-low, priority over everything.
  - Edge with rst_n=0 gives state=IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, digit counter=0, internal carry=0.
  - Applies mid-RUN too: the operation is discarded and no done is produced.
- States:
  - IDLE:
    - start=1 at edge k: capture a, b, cin into shift/operand registers; counter=0; go to RUN.
    - start=0: stay in IDLE.
  - RUN:
    - busy=1.
    - Each edge adds digit[counter] of A and B plus the registered carry.
    - Writes the DIGIT-bit result into sum[counter*DIGIT +: DIGIT], updates the carry, and increments the counter.
    - On the edge processing digit STEPS-1:
      - cout = final carry.
      - ovf = (A[MSB]==B[MSB]) && (sum[MSB] != A[MSB]).
      - Go to DONE.
  - DONE:
    - done=1 and busy=0 for exactly this one cycle.
    - Next edge: if start=1, accept new operands and go to RUN (back-to-back); else go to IDLE.
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+STEPS (8 cycles for the defaults). Throughput is one result per STEPS+1 cycles.
- start while in RUN is ignored; the operand inputs are don't-care after capture.
- sum, cout and ovf:
  - Hold their last result through IDLE until the next accepted start.
  - Values during RUN are partial and only guaranteed at done.
  - At accept, sum, cout and ovf are not cleared: low digits are overwritten progressively.
- Arithmetic is modulo 2^WIDTH; {cout,sum} equals a+b+cin exactly.
- Wrap: the counter is exactly ceil(log2(STEPS)) bits wide (minimum 1). No counter overflow past STEPS-1.
- DIGIT=WIDTH is legal: STEPS=1, one RUN cycle, and done follows 1 cycle after accept.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 edges, then release with start=0 → sum=0, cout=0, ovf=0, busy=0, done=0 are held indefinitely.
- Basic add (WIDTH=8, DIGIT=1): a=8'h3C, b=8'h05, cin=0, start pulse → busy=1 for 8 cycles; done 1 cycle after → sum=8'h41, cout=0, ovf=0.
- Carry and overflow:
  - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0.
  - a=8'h7F, b=8'h01, cin=1 → sum=8'h81, cout=0, ovf=1.
- Back-to-back and ignored start:
  - Hold start=1 continuously with operands changing every cycle.
  - Required: results only for the operands present on the accept edges, which are spaced 9 cycles apart.
  - done pulses exactly once per operation.
- Reset mid-operation: assert rst_n=0 at RUN cycle 4 of a=8'hAA, b=8'h55 → next cycle state=IDLE, all outputs 0, and no done afterwards.
- Parameter sweep: instantiate (WIDTH=16, DIGIT=4) and (WIDTH=8, DIGIT=8).
  - Run 1000 random operand sets per configuration, compared against a+b+cin.
  - Required done latencies: 5 and 2 cycles respectively, measured as accept edge to done-cycle edge (STEPS+1).
